// File: rtl/ula_controle.sv
// rtl/ula_controle.sv - command FIFO and IDLE/EXEC/HOLD sequencer feeding the combinational ula
`timescale 1ns/1ps
module ula_controle #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_sel,
    input  logic [1:0]                    cmd_a,
    input  logic                          cmd_b,
    output logic [3:0]                    ula_sel,
    output logic [1:0]                    ula_a,
    output logic                          ula_b,
    input  logic [2:0]                    ula_saida,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [2:0]                    res_dado,
    output logic [3:0]                    res_sel,
    output logic                          res_erro,
    output logic [$clog2(FIFO_DEPTH):0]   ocupacao,
    output logic [CNT_W-1:0]              cont_ops
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t        state, state_nxt;
    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // No bypass: a full FIFO refuses commands even when it pops this cycle.
    assign cmd_ready = !rst && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign ocupacao  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_sel, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ula_* only move on a pop, so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ula_sel   <= '0;
            ula_a     <= '0;
            ula_b     <= 1'b0;
            res_valid <= 1'b0;
            res_dado  <= '0;
            res_sel   <= '0;
            res_erro  <= 1'b0;
            cont_ops  <= '0;
        end else begin
            if (pop) begin
                {ula_sel, ula_a, ula_b} <= mem[rd_ptr];
            end
            if (state == EXEC) begin
                res_valid <= 1'b1;
                res_sel   <= ula_sel;
                if (ula_sel == 4'b0011 && !ula_b) begin
                    res_dado <= 3'b000;
                    res_erro <= 1'b1;
                end else begin
                    res_dado <= ula_saida;
                    res_erro <= 1'b0;
                end
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
                cont_ops  <= cont_ops + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ula_controle.sv
// tb/tb_ula_controle.sv - scoreboard bench for ula_controle with a reference ALU and command model
`timescale 1ns/1ps
module tb_ula_controle;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_valid, res_ready;
    logic [3:0] cmd_sel;
    logic [1:0] cmd_a;
    logic       cmd_b;

    logic       cmd_ready, res_valid, res_erro, ula_b;
    logic [3:0] ula_sel, res_sel;
    logic [1:0] ula_a;
    logic [2:0] ula_saida, res_dado, ocupacao;
    logic [7:0] cont_ops;

    logic       cmd_ready2, res_valid2, res_erro2, ula_b2;
    logic [3:0] ula_sel2, res_sel2;
    logic [1:0] ula_a2;
    logic [2:0] ula_saida2, res_dado2, ocupacao2;
    logic [1:0] cont2;

    typedef struct {
        logic [3:0] sel;
        logic [2:0] dado;
        logic       erro;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0, fails = 0;
    int         ops_done = 0, n_results = 0;
    logic [2:0] last_dado;
    logic [3:0] last_sel;
    logic       last_erro;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_dado;
    bit         rand_rdy = 1'b0;

    // Reference ALU; a zero divisor yields junk that the sequencer must replace.
    function automatic logic [2:0] alu(input logic [3:0] s, input logic [1:0] a, input logic b);
        int x = a;
        int y = b;
        int r;
        case (s)
            0:  r = x + y;
            1:  r = x - y;
            2:  r = x * y;
            3:  r = (y == 0) ? 5 : x / y;
            4:  r = x & y;
            5:  r = x | y;
            6:  r = x ^ y;
            7:  r = ~(x & y);
            8:  r = ~(x | y);
            9:  r = ~(x ^ y);
            10: r = ~x;
            11: r = x << y;
            12: r = x >> y;
            13: r = (x > y) ? 1 : 0;
            14: r = (x < y) ? 1 : 0;
            default: r = (x == y) ? 1 : 0;
        endcase
        return r[2:0];
    endfunction

    function automatic exp_t model(input logic [3:0] s, input logic [1:0] a, input logic b);
        exp_t e;
        e.sel = s;
        if (s == 4'd3 && b == 1'b0) begin
            e.dado = 3'b000;
            e.erro = 1'b1;
        end else begin
            e.dado = alu(s, a, b);
            e.erro = 1'b0;
        end
        return e;
    endfunction

    always_comb ula_saida  = alu(ula_sel, ula_a, ula_b);
    always_comb ula_saida2 = alu(ula_sel2, ula_a2, ula_b2);

    ula_controle #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .ula_sel(ula_sel), .ula_a(ula_a), .ula_b(ula_b), .ula_saida(ula_saida),
        .res_valid(res_valid), .res_ready(res_ready), .res_dado(res_dado),
        .res_sel(res_sel), .res_erro(res_erro), .ocupacao(ocupacao), .cont_ops(cont_ops)
    );

    ula_controle #(.FIFO_DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .ula_sel(ula_sel2), .ula_a(ula_a2), .ula_b(ula_b2), .ula_saida(ula_saida2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_dado(res_dado2),
        .res_sel(res_sel2), .res_erro(res_erro2), .ocupacao(ocupacao2), .cont_ops(cont2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ops_done   = 0;
            prev_stall = 1'b0;
        end else begin
            check("cont_ops", 32'(cont_ops), ops_done % 256);
            check("cont_ops_w2", 32'(cont2), ops_done % 4);
            if (prev_stall && res_valid) check("res_dado_held", 32'(res_dado), 32'(prev_dado));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_dado), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_dado", 32'(res_dado), 32'(e.dado));
                    check("res_sel", 32'(res_sel), 32'(e.sel));
                    check("res_erro", 32'(res_erro), 32'(e.erro));
                end
                last_dado = res_dado;
                last_sel  = res_sel;
                last_erro = res_erro;
                n_results++;
                ops_done++;
            end
            prev_stall = res_valid && !res_ready;
            prev_dado  = res_dado;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [3:0] s, input logic [1:0] a, input logic b, input int max_wait);
        bit ok = 1'b0;
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(model(s, a, b));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid && ocupacao == 0) done = 1'b1;
        end
        if (!done) check(nm, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_in_reset", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_ocupacao", 32'(ocupacao), 0);
        check("rst_cont_ops", 32'(cont_ops), 0);
        check("rst_ula", 32'({ula_sel, ula_a, ula_b}), 0);
        check("rst_res", 32'({res_dado, res_sel, res_erro}), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, idx, base;
        logic [6:0] cmds [6];
        int cnt2_exp [4] = '{1, 2, 3, 0};

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_sel = '0; cmd_a = '0; cmd_b = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Latency and add
        res_ready = 1'b1;
        send(4'b0000, 2'b11, 1'b1, 5);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (res_valid) break;
        end
        check("latency", lat, 2);
        wait_idle("idle_t1");
        check("t1_dado", 32'(last_dado), 4);
        check("t1_erro", 32'(last_erro), 0);
        check("t1_cont_ops", 32'(cont_ops), 1);

        // Division by zero then a legal division
        send(4'b0011, 2'b10, 1'b0, 5);
        wait_idle("idle_t2a");
        check("t2_div0_dado", 32'(last_dado), 0);
        check("t2_div0_erro", 32'(last_erro), 1);
        check("t2_div0_sel", 32'(last_sel), 3);
        send(4'b0011, 2'b11, 1'b1, 5);
        wait_idle("idle_t2b");
        check("t2_div_dado", 32'(last_dado), 3);
        check("t2_div_erro", 32'(last_erro), 0);

        // Subtract wrap and equality
        send(4'b0001, 2'b00, 1'b1, 5);
        wait_idle("idle_t3a");
        check("t3_sub_dado", 32'(last_dado), 7);
        send(4'b1111, 2'b01, 1'b1, 5);
        wait_idle("idle_t3b");
        check("t3_eq_dado", 32'(last_dado), 1);

        // Backpressure: six offers, five fit
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) cmds[i] = 7'($urandom);
        idx = 0; acc = 0; base = n_results;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (idx < 6);
            if (idx < 6) {cmd_sel, cmd_a, cmd_b} = cmds[idx];
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(cmd_sel, cmd_a, cmd_b));
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t4_accepted", acc, 5);
        check("t4_cmd_ready_full", 32'(cmd_ready), 0);
        check("t4_ocupacao", 32'(ocupacao), 4);
        check("t4_res_valid", 32'(res_valid), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle("idle_t4");
        check("t4_results", n_results - base, 5);

        // Reset while holding a result with two queued
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'($urandom), 2'($urandom), 1'($urandom), 5);
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid && ocupacao == 2) begin idx = 1; break; end
        end
        check("t5_reach_hold", idx, 1);
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_no_stale_result", 32'(res_valid), 0);
        @(posedge clk);
        #1;

        // Narrow counter wraps
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(4'($urandom), 2'($urandom), 1'($urandom), 5);
            wait_idle("idle_t6");
            check("t6_cont_w2", 32'(cont2), cnt2_exp[i]);
        end

        // Randomized traffic, long enough to wrap the 8-bit counter
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(4'($urandom), 2'($urandom), 1'($urandom), 60);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle("idle_random");
        check("scoreboard_empty", exp_q.size(), 0);
        check("random_cont_ops", 32'(cont_ops), 304 % 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
